// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: execute-stage to data-memory request/response bundle.
interface data_mem_responder_if;
  logic [31:0] data_addr;
  logic [31:0] data_write;
  logic [3:0]  data_write_byte;
  logic        data_write_valid;
  logic        data_read_valid;
  logic        req_ready;
  logic [31:0] data_read;
  logic        data_read_done;
  logic        misaligned_fault;
  logic        parity_error;
  modport master(output data_addr, data_write, data_write_byte, data_write_valid, data_read_valid,
                 input req_ready, data_read, data_read_done, misaligned_fault, parity_error);
  modport slave(input data_addr, data_write, data_write_byte, data_write_valid, data_read_valid,
                output req_ready, data_read, data_read_done, misaligned_fault, parity_error);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-lane data RAM with fixed-latency word reads and misalignment rejection.
// Define DMEM_PARITY_EN to store one even-parity bit per byte lane and flag mismatches on read.
module data_mem_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input logic clk,
  input logic reset,
  data_mem_responder_if.slave bus
);
  typedef enum logic {IDLE, READ_WAIT} state_t;
  state_t r_state, w_next;
  logic [1:0] r_cnt, w_cnt;
  logic [ADDR_WIDTH-1:0] r_idx, w_idx, w_rd_idx;
  logic [31:0] r_mem [2**ADDR_WIDTH];
  logic [31:0] r_data;
  logic [3:0] w_wmask;
  logic r_done, r_fault, w_ready, w_mis, w_wr_acc, w_rd_acc, w_done_set, w_fault_set, w_unused;
  assign w_idx = bus.data_addr[ADDR_WIDTH+1:2];
  assign w_unused = ^bus.data_addr[31:ADDR_WIDTH+2];
  assign w_mis = (bus.data_write_byte == 4'b0011 && bus.data_addr[1:0] == 2'd3) ||
                 (bus.data_write_byte == 4'b1111 && bus.data_addr[1:0] != 2'd0);
  assign w_wmask = 4'(bus.data_write_byte << bus.data_addr[1:0]);
  assign w_ready = r_state == IDLE && !reset;
  // No writes are accepted while waiting, so the read can sample the RAM at completion.
  assign w_rd_idx = r_state == IDLE ? w_idx : r_idx;
  assign bus.req_ready = w_ready;
  assign bus.data_read = r_data;
  assign bus.data_read_done = r_done;
  assign bus.misaligned_fault = r_fault;
  always_comb begin
    w_next = r_state;
    w_cnt = r_cnt;
    w_wr_acc = 1'b0;
    w_rd_acc = 1'b0;
    w_done_set = 1'b0;
    w_fault_set = 1'b0;
    if (r_state == IDLE) begin
      w_wr_acc = w_ready && bus.data_write_valid && !w_mis;
      w_fault_set = w_ready && bus.data_write_valid && w_mis;
      w_rd_acc = w_ready && bus.data_read_valid && !bus.data_write_valid;
      w_next = w_rd_acc ? READ_WAIT : IDLE;
      w_cnt = w_rd_acc ? 2'(READ_LATENCY - 1) : r_cnt;
      w_done_set = w_rd_acc && READ_LATENCY == 1;
    end else begin
      w_next = r_cnt == 2'd0 ? IDLE : READ_WAIT;
      w_cnt = r_cnt == 2'd0 ? 2'd0 : r_cnt - 2'd1;
      w_done_set = r_cnt == 2'd1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= 2'd0;
      r_idx <= '0;
      r_data <= 32'd0;
      r_done <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt;
      r_done <= w_done_set;
      r_fault <= w_fault_set;
      if (w_rd_acc) r_idx <= w_idx;
      if (w_done_set) r_data <= r_mem[w_rd_idx];
    end
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (w_wr_acc && w_wmask[k]) r_mem[w_idx][8*k+:8] <= bus.data_write[8*k+:8];
  end
`ifdef DMEM_PARITY_EN
  logic [3:0] r_par [2**ADDR_WIDTH];
  logic [31:0] w_rd_word;
  logic w_par_bad, r_perr;
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (w_wr_acc && w_wmask[k]) r_par[w_idx][k] <= ^bus.data_write[8*k+:8];
  end
  always_comb begin
    w_rd_word = r_mem[w_rd_idx];
    w_par_bad = 1'b0;
    for (int k = 0; k < 4; k++) w_par_bad = w_par_bad | ((^w_rd_word[8*k+:8]) != r_par[w_rd_idx][k]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_perr <= 1'b0;
    else r_perr <= w_done_set && w_par_bad;
  end
  assign bus.parity_error = r_perr;
`else
  assign bus.parity_error = 1'b0;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: three responders (read latency 1, 2, 3) checked against a word-array model.
module tb_data_mem_responder;
  localparam int AW = 10;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] t_addr [3];
  logic [31:0] t_wd [3];
  logic [3:0] t_m [3];
  logic t_wv [3];
  logic t_rv [3];
  logic o_rdy [3];
  logic o_done [3];
  logic o_flt [3];
  logic o_perr [3];
  logic [31:0] o_rd [3];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder_if bus();
    assign bus.data_addr = t_addr[g];
    assign bus.data_write = t_wd[g];
    assign bus.data_write_byte = t_m[g];
    assign bus.data_write_valid = t_wv[g];
    assign bus.data_read_valid = t_rv[g];
    assign o_rdy[g] = bus.req_ready;
    assign o_done[g] = bus.data_read_done;
    assign o_flt[g] = bus.misaligned_fault;
    assign o_perr[g] = bus.parity_error;
    assign o_rd[g] = bus.data_read;
    data_mem_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(g + 1)) dut (.clk(clk), .reset(reset), .bus(bus));
  end
  int errs = 0;
  int checks = 0;
  logic [31:0] ref_mem [3][2**AW];
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0] m;
    logic wv;
    logic rv;
    logic ef;
    logic ed;
    logic [31:0] er;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(2**AW));
  endfunction
  function automatic logic is_mis(input logic [31:0] a, input logic [3:0] m);
    return (m == 4'b0011 || m == 4'b1111) && (int'(a % 32'd4) + $countones(m) > 4);
  endfunction
  task automatic mwrite(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    int off;
    int w;
    off = int'(a % 32'd4);
    w = widx(a);
    for (int k = 0; k < 4; k++)
      if (k >= off && m[k-off]) ref_mem[i][w][8*k+:8] = d[8*k+:8];
  endtask
  task automatic clr(input int i);
    t_wv[i] = 1'b0;
    t_rv[i] = 1'b0;
  endtask
  task automatic req(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                     input logic wv, input logic rv, input string nm,
                     output int ndone, output int nflt, output logic [31:0] rd);
    int w;
    int lat;
    int flat;
    logic perr;
    logic emis;
    logic [31:0] exp;
    @(negedge clk);
    t_addr[i] = a; t_wd[i] = d; t_m[i] = m; t_wv[i] = wv; t_rv[i] = rv;
    w = 0;
    while (!o_rdy[i] && w < 8) begin
      @(negedge clk);
      w++;
    end
    ndone = 0; nflt = 0; rd = 32'd0;
    if (!o_rdy[i]) begin
      chk({nm, " accept timeout"}, 32'd0, 32'd1);
      clr(i);
      return;
    end
    emis = is_mis(a, m);
    exp = ref_mem[i][widx(a)];
    if (wv && !emis) mwrite(i, a, d, m);
    @(posedge clk);
    @(negedge clk);
    clr(i);
    lat = 0; flat = 0; perr = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      if (o_done[i]) begin
        ndone++;
        if (lat == 0) begin
          lat = n;
          rd = o_rd[i];
        end
        perr = perr | o_perr[i];
      end
      if (o_flt[i]) begin
        nflt++;
        if (flat == 0) flat = n;
      end
      @(negedge clk);
    end
    chk({nm, " fault count"}, 32'(nflt), (wv && emis) ? 32'd1 : 32'd0);
    chk({nm, " done count"}, 32'(ndone), (rv && !wv) ? 32'd1 : 32'd0);
    if (wv && emis) chk({nm, " fault cycle"}, 32'(flat), 32'd1);
    if (rv && !wv) begin
      chk({nm, " latency"}, 32'(lat), 32'(i + 1));
      chk({nm, " data"}, rd, exp);
      chk({nm, " parity"}, 32'(perr), 32'd0);
    end
  endtask
  int nd, nf, cnt;
  logic [31:0] rd, a, exp;
  logic [3:0] m;
  initial begin
    for (int i = 0; i < 3; i++) begin
      t_addr[i] = 32'd0; t_wd[i] = 32'd0; t_m[i] = 4'd0; t_wv[i] = 1'b0; t_rv[i] = 1'b0;
    end
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset ready", 32'(o_rdy[i]), 32'd0);
      chk("reset done", 32'(o_done[i]), 32'd0);
      chk("reset fault", 32'(o_flt[i]), 32'd0);
      chk("reset parity", 32'(o_perr[i]), 32'd0);
      chk("reset data", o_rd[i], 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("ready after reset", 32'(o_rdy[i]), 32'd1);
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 64; w++) req(i, 32'(w * 4), $urandom | 32'd1, 4'hF, 1'b1, 1'b0, "prefill", nd, nf, rd);
    tbl.push_back('{32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{32'h10, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF});
    tbl.push_back('{32'h10, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{32'h13, 32'h55555555, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{32'h10, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h55000000});
    tbl.push_back('{32'h12, 32'hABCDABCD, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{32'h10, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hABCD0000});
    tbl.push_back('{32'h11, 32'hAAAAAAAA, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{32'h10, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hABCDAA00});
    tbl.push_back('{32'h11, 32'h12341234, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{32'h10, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hAB341200});
    tbl.push_back('{32'h20, 32'h11111111, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{32'h24, 32'h22222222, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{32'h23, 32'hFFFFFFFF, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{32'h21, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{32'h20, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111});
    tbl.push_back('{32'h24, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h22222222});
    tbl.push_back('{32'h40, 32'h12345678, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{32'h40, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678});
    tbl.push_back('{32'h1040, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678});
    tbl.push_back('{32'h1044, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{32'h44, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D});
    tbl.push_back('{32'h44, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{32'h44, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D});
    tbl.push_back('{32'h46, 32'hBEEFBEEF, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{32'h44, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hBEEFF00D});
    for (int t = 0; t < tbl.size(); t++) begin
      req(0, tbl[t].a, tbl[t].d, tbl[t].m, tbl[t].wv, tbl[t].rv, "vector", nd, nf, rd);
      chk("vec fault", 32'(nf), 32'(tbl[t].ef));
      chk("vec done", 32'(nd), 32'(tbl[t].ed));
      if (tbl[t].ed) chk("vec data", rd, tbl[t].er);
    end
    // back-to-back write then read of the same word on the latency-1 responder
    @(negedge clk);
    t_addr[0] = 32'h83; t_wd[0] = 32'h77777777; t_m[0] = 4'h1; t_wv[0] = 1'b1;
    chk("raw write ready", 32'(o_rdy[0]), 32'd1);
    mwrite(0, 32'h83, 32'h77777777, 4'h1);
    exp = ref_mem[0][32];
    @(posedge clk);
    @(negedge clk);
    t_wv[0] = 1'b0; t_addr[0] = 32'h80; t_rv[0] = 1'b1;
    chk("raw read ready", 32'(o_rdy[0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    t_rv[0] = 1'b0;
    chk("raw done", 32'(o_done[0]), 32'd1);
    chk("raw data", o_rd[0], exp);
    chk("raw data byte3", 32'(o_rd[0][31:24]), 32'h77);
    repeat (2) @(negedge clk);
    // latency-3 read with a write held during the wait
    t_addr[2] = 32'h10; t_rv[2] = 1'b1;
    exp = ref_mem[2][4];
    chk("l3 ready", 32'(o_rdy[2]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    t_rv[2] = 1'b0; t_addr[2] = 32'h30; t_wd[2] = 32'h5A5A5A5A; t_m[2] = 4'hF; t_wv[2] = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      chk("l3 wait ready", 32'(o_rdy[2]), 32'd0);
      chk("l3 done timing", 32'(o_done[2]), n == 3 ? 32'd1 : 32'd0);
      if (n == 3) chk("l3 data", o_rd[2], exp);
      @(negedge clk);
    end
    chk("l3 ready back", 32'(o_rdy[2]), 32'd1);
    chk("l3 no extra done", 32'(o_done[2]), 32'd0);
    mwrite(2, 32'h30, 32'h5A5A5A5A, 4'hF);
    @(posedge clk);
    @(negedge clk);
    t_wv[2] = 1'b0;
    req(2, 32'h30, 32'h0, 4'h0, 1'b0, 1'b1, "l3 readback", nd, nf, rd);
    chk("l3 held write", rd, 32'h5A5A5A5A);
    // reset one cycle into a latency-2 read
    req(1, 32'h10, 32'h0, 4'h0, 1'b0, 1'b1, "l2 preload", nd, nf, rd);
    @(negedge clk);
    t_addr[1] = 32'h14; t_rv[1] = 1'b1;
    chk("l2 ready", 32'(o_rdy[1]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    t_rv[1] = 1'b0;
    reset = 1'b1;
    #1;
    chk("midreset ready", 32'(o_rdy[1]), 32'd0);
    chk("midreset done", 32'(o_done[1]), 32'd0);
    chk("midreset fault", 32'(o_flt[1]), 32'd0);
    chk("midreset data", o_rd[1], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < 4; n++) begin
      cnt += int'(o_done[1]);
      @(negedge clk);
    end
    chk("midreset no done", 32'(cnt), 32'd0);
    chk("midreset ready after", 32'(o_rdy[1]), 32'd1);
`ifdef DMEM_PARITY_EN
    g_dut[0].dut.r_par[5][2] = ~g_dut[0].dut.r_par[5][2];
    @(negedge clk);
    t_addr[0] = 32'h14; t_rv[0] = 1'b1;
    exp = ref_mem[0][5];
    @(posedge clk);
    @(negedge clk);
    t_rv[0] = 1'b0;
    chk("parity done", 32'(o_done[0]), 32'd1);
    chk("parity flag", 32'(o_perr[0]), 32'd1);
    chk("parity data", o_rd[0], exp);
    @(negedge clk);
    chk("parity pulse", 32'(o_perr[0]), 32'd0);
    req(0, 32'h14, exp, 4'hF, 1'b1, 1'b0, "parity repair", nd, nf, rd);
`endif
    for (int r = 0; r < 400; r++) begin
      int i;
      int kind;
      i = int'($urandom_range(0, 2));
      kind = int'($urandom_range(0, 5));
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
      case ($urandom_range(0, 4))
        0: m = 4'b0001;
        1: m = 4'b0011;
        2: m = 4'b1111;
        3: m = 4'b0000;
        default: m = 4'($urandom);
      endcase
      req(i, a, $urandom, m, kind < 3 || kind == 5, kind >= 3, "random", nd, nf, rd);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Data-memory responder for the single-cycle RISC-V datapath. It services the store and load requests that the execute stage drives: a byte address, replicated store data, a lane-0-relative byte mask, and write/read valids. It provides byte-lane writes, fixed-latency word reads, misalignment detection and a request-ready handshake. It sits between the execute stage and the on-chip data RAM and returns the raw aligned word; the execute stage performs sign/zero extraction.

Parameters:
ADDR_WIDTH, 10, word-address bits; memory depth = 2**ADDR_WIDTH 32-bit words
READ_LATENCY, 1, cycles from read accept to data_read_done; legal range 1..3

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
data_addr  input  32  byte address of request
data_write  input  32  store data, replicated per SB/SH/SW
data_write_byte  input  4  lane-0-relative mask: 0001 SB, 0011 SH, 1111 SW
data_write_valid  input  1  store request
data_read_valid  input  1  load request
req_ready  output  1  request accepted this cycle when valid && req_ready
data_read  output  32  aligned word read; holds until next read completes
data_read_done  output  1  one-cycle pulse, data_read valid
misaligned_fault  output  1  one-cycle pulse, rejected request
parity_error  output  1  one-cycle pulse with data_read_done (optional feature)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, latency counter 0. RAM contents are not reset.
- Word index = data_addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo the memory size.
- Misalignment rules:
  - mask 0011 with data_addr[1:0]==3 is misaligned.
  - mask 1111 with data_addr[1:0]!=0 is misaligned.
  - Read alignment is not checked; reads always return the full word.
- Effective write mask = data_write_byte << data_addr[1:0], truncated to 4 bits.
- Each enabled lane k writes data_write[8k+7:8k]. A mask of 0000 is accepted as a no-op.
- FSM states:
  - IDLE: req_ready=1.
    - Write accepted: commits on the same clock edge (0-cycle write latency); stays in IDLE.
    - Misaligned write: no RAM change; misaligned_fault=1 next cycle; stays in IDLE.
    - Read accepted: RAM read issued, counter loaded with READ_LATENCY-1; go to READ_WAIT. If READ_LATENCY==1, data_read_done asserts the next cycle and the FSM returns to IDLE.
  - READ_WAIT: req_ready=0; new requests are ignored and must be held by the requester. The counter decrements each cycle; at 0, data_read is registered, data_read_done pulses and the FSM returns to IDLE.
- Simultaneous data_write_valid and data_read_valid in IDLE: the write wins and the read is dropped, not queued.
- Read-after-write: a read accepted the cycle after a write to the same word returns the updated bytes.
- Reset asserted mid-read: the read is abandoned with no data_read_done pulse, and data_read clears to 0.
- data_read_done and misaligned_fault never assert in the same cycle.

Optional Feature:
DMEM_PARITY_EN
- Defined: one even-parity bit is stored per byte lane and written with that lane. On read completion the four parity bits are recomputed and compared. Any mismatch pulses parity_error in the same cycle as data_read_done; data_read is still returned. Parity RAM is not reset, so reading a never-written word may flag an error.
- Undefined: no parity storage; parity_error is tied to 0.

Test Plan:
- Reset then SW 0xDEADBEEF at addr 0x10 (mask 1111); read addr 0x10 → data_read=0xDEADBEEF with data_read_done exactly READ_LATENCY cycles after accept.
- SB 0x55555555 with mask 0001 at addr 0x13 over word 0x00000000 → read 0x10 returns 0x55000000. SH 0xABCDABCD with mask 0011 at addr 0x12 → read returns 0xABCD0000.
- SH at addr 0x23 and SW at addr 0x21 → misaligned_fault pulses once each; a subsequent read of words 0x20 and 0x24 shows no change.
- READ_LATENCY=3: read accepted → req_ready=0 for 3 cycles. A write asserted during the wait is not accepted until req_ready returns high; it then commits on that accepting edge (read-back confirms).
- Write and read valid together at addr 0x40 with 0x12345678 → write commits, no data_read_done; a following read returns 0x12345678. Address 0x40 + (4 << ADDR_WIDTH) aliases to the same word.
- Assert reset 1 cycle after read accept (READ_LATENCY=2) → no data_read_done, all outputs 0. With DMEM_PARITY_EN, flip a stored parity bit via backdoor → read pulses parity_error with data_read_done.
